// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared encodings and constants for the DHT11 UART reporter
package dht11_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CONVERT   = 3'd1;
    localparam logic [2:0] ST_SEND      = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_FREE = 3'd4;

    // ASCII characters used in the report line
    localparam logic [7:0] CHAR_EQ  = 8'h3D;
    localparam logic [7:0] CHAR_PCT = 8'h25;
    localparam logic [7:0] CHAR_SP  = 8'h20;
    localparam logic [7:0] CHAR_C   = 8'h43;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] ZERO     = 8'h30;

    // Integer-byte fields inside the 40-bit DHT11 frame
    localparam int HUM_MSB  = 39;
    localparam int HUM_LSB  = 32;
    localparam int TEMP_MSB = 23;
    localparam int TEMP_LSB = 16;

    // Map one BCD nibble to its ASCII digit
    function automatic logic [7:0] bcd_ascii(input logic [3:0] nib);
        return ZERO + {4'h0, nib};
    endfunction

endpackage

// File: rtl/bin8_to_bcd.sv
// rtl/bin8_to_bcd.sv - sequential 8-bit binary to 3-digit BCD converter (double dabble)
module bin8_to_bcd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_bin,
    output logic        o_done,
    output logic [11:0] o_bcd
);

    // {bcd[11:0], binary[7:0]} working register; the binary half doubles as the input latch
    logic [19:0] r_shift;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic [11:0] r_bcd;

    logic [11:0] w_adj;
    logic [19:0] w_step;

    // Add 3 to every BCD nibble that is 5 or more, then shift the whole register left
    always_comb begin
        w_adj = r_shift[19:8];
        for (int i = 0; i < 3; i++) begin
            if (r_shift[8 + 4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_shift[8 + 4*i +: 4] + 4'd3;
            end
        end
        w_step = {w_adj[10:0], r_shift[7:0], 1'b0};
    end

    // Load on start, iterate eight times, publish the result on the last iteration only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 20'h0;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b0;
            r_bcd   <= 12'h000;
        end else if (i_start) begin
            r_shift <= {12'h000, i_bin};
            r_cnt   <= 3'd0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_shift <= w_step;
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_busy <= 1'b0;
                r_bcd  <= w_step[19:8];
            end
        end
    end

    // Done marks the cycle whose closing edge registers the result
    assign o_done = r_busy && (r_cnt == 3'd7);
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/dht11_uart_reporter.sv
// rtl/dht11_uart_reporter.sv - converts DHT11 humidity/temperature to BCD and streams an ASCII line to uart_tx
module dht11_uart_reporter
    import dht11_pkg::*;
#(
    parameter int         ADD_CRLF  = 1,
    parameter logic [7:0] HUM_CHAR  = 8'h48,
    parameter logic [7:0] TEMP_CHAR = 8'h54
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] data,
    input  logic        done,
    input  logic        vaild,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [11:0] hum_bcd,
    output logic [11:0] temp_bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic        dropped
);

    localparam int         LEN      = (ADD_CRLF != 0) ? 15 : 13;
    localparam logic [3:0] LAST_IDX = 4'(LEN - 1);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [3:0] r_idx;
    logic       r_bcd_valid;

    logic       w_frame_ok;
    logic       w_accept;
    logic       w_hum_done;
    logic       w_temp_done;
    logic       w_conv_done;
    logic [7:0] w_msg_byte;
    logic       w_send_now;
    logic       w_unused_bits;

    assign w_frame_ok    = done & vaild;
    assign w_accept      = w_frame_ok && (r_state == ST_IDLE);
    assign w_conv_done   = w_hum_done & w_temp_done;
    assign w_unused_bits = ^{data[31:24], data[15:0]};

    // The converters' input registers are the latch for the accepted frame
    bin8_to_bcd u_hum_bcd (
        .clk     (clk),
        .rst_n   (rst),
        .i_start (w_accept),
        .i_bin   (data[HUM_MSB:HUM_LSB]),
        .o_done  (w_hum_done),
        .o_bcd   (hum_bcd)
    );

    bin8_to_bcd u_temp_bcd (
        .clk     (clk),
        .rst_n   (rst),
        .i_start (w_accept),
        .i_bin   (data[TEMP_MSB:TEMP_LSB]),
        .o_done  (w_temp_done),
        .o_bcd   (temp_bcd)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (w_frame_ok)   w_next_state = ST_CONVERT;
            ST_CONVERT:   if (w_conv_done)  w_next_state = ST_SEND;
            ST_SEND:      if (!tx_busy)     w_next_state = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (tx_busy)      w_next_state = ST_WAIT_FREE;
            ST_WAIT_FREE: begin
                if (!tx_busy) begin
                    w_next_state = (r_idx == LAST_IDX) ? ST_IDLE : ST_SEND;
                end
            end
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Outputs: one strobe per SEND visit, only while the uart is free
    always_comb begin
        w_send_now = (r_state == ST_SEND) && !tx_busy;
        tx_start   = w_send_now;
        tx_data    = w_send_now ? w_msg_byte : 8'h00;
        busy       = (r_state != ST_IDLE);
        dropped    = w_frame_ok && (r_state != ST_IDLE);
    end

    // Byte index advances once the uart has finished the current byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= 4'd0;
        end else if ((r_state == ST_WAIT_FREE) && !tx_busy) begin
            r_idx <= (r_idx == LAST_IDX) ? 4'd0 : r_idx + 4'd1;
        end
    end

    // Sticky flag: BCD outputs hold a real conversion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcd_valid <= 1'b0;
        end else if ((r_state == ST_CONVERT) && w_conv_done) begin
            r_bcd_valid <= 1'b1;
        end
    end

    assign bcd_valid = r_bcd_valid;

    // Message byte selection by index
    always_comb begin
        w_msg_byte = 8'h00;
        case (r_idx)
            4'd0:    w_msg_byte = HUM_CHAR;
            4'd1:    w_msg_byte = CHAR_EQ;
            4'd2:    w_msg_byte = bcd_ascii(hum_bcd[11:8]);
            4'd3:    w_msg_byte = bcd_ascii(hum_bcd[7:4]);
            4'd4:    w_msg_byte = bcd_ascii(hum_bcd[3:0]);
            4'd5:    w_msg_byte = CHAR_PCT;
            4'd6:    w_msg_byte = CHAR_SP;
            4'd7:    w_msg_byte = TEMP_CHAR;
            4'd8:    w_msg_byte = CHAR_EQ;
            4'd9:    w_msg_byte = bcd_ascii(temp_bcd[11:8]);
            4'd10:   w_msg_byte = bcd_ascii(temp_bcd[7:4]);
            4'd11:   w_msg_byte = bcd_ascii(temp_bcd[3:0]);
            4'd12:   w_msg_byte = CHAR_C;
            4'd13:   w_msg_byte = CR;
            4'd14:   w_msg_byte = LF;
            default: w_msg_byte = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// tb/tb_dht11_uart_reporter.sv - scoreboard bench for dht11_uart_reporter
module tb_dht11_uart_reporter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [39:0] data = 40'h0;
    logic        done = 1'b0;
    logic        vaild = 1'b0;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [11:0] hum_bcd;
    logic [11:0] temp_bcd;
    logic        bcd_valid;
    logic        busy;
    logic        dropped;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ucnt = 0;
    logic force_busy = 1'b0;
    logic prev_start = 1'b0;
    int n_strobes = 0;
    int n_dropped = 0;
    logic lat_armed = 1'b0;
    int lat_cyc = 0;
    int t_done = 0;
    logic [7:0] q[$];

    dht11_uart_reporter dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .done      (done),
        .vaild     (vaild),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .hum_bcd   (hum_bcd),
        .temp_bcd  (temp_bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx model: busy for 10 cycles after each strobe
    always @(posedge clk) begin
        if (tx_start) ucnt <= 10;
        else if (ucnt > 0) ucnt <= ucnt - 1;
    end
    assign tx_busy = (ucnt != 0) || force_busy;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: pop expected bytes whenever the DUT strobes
    always @(negedge clk) begin
        if (rst) begin
            if (tx_start) begin
                check("start_while_busy", {31'h0, tx_busy}, 32'h0);
                check("start_back_to_back", {31'h0, prev_start}, 32'h0);
                if (q.size() == 0) begin
                    check("unexpected_strobe", {24'h0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", {24'h0, tx_data}, {24'h0, q.pop_front()});
                end
                if (lat_armed) begin
                    lat_cyc = cyc;
                    lat_armed = 1'b0;
                end
                n_strobes++;
            end
            if (dropped) n_dropped++;
        end
        prev_start = tx_start;
    end

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        q.push_back(8'h0D);
        q.push_back(8'h0A);
    endtask

    task automatic send_frame(input logic [39:0] d, input logic v);
        @(posedge clk); #1;
        data = d; done = 1'b1; vaild = v; t_done = cyc;
        @(posedge clk); #1;
        done = 1'b0; vaild = 1'b0;
    endtask

    task automatic wait_line(input int budget);
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("line_timeout", {31'h0, (n < budget)}, 32'h1);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n;
        n = 0;
        while (n_strobes < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("strobe_wait_timeout", {31'h0, (n < budget)}, 32'h1);
    endtask

    initial begin
        int base;
        int dbase;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_start", {31'h0, tx_start}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_bcd_valid", {31'h0, bcd_valid}, 32'h0);
        check("rst_hum_bcd", {20'h0, hum_bcd}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: 45 %RH / 27 C, with first-strobe latency
        base = n_strobes;
        push_line("H=045% T=027C");
        lat_armed = 1'b1;
        send_frame(40'h2D_00_1B_00_48, 1'b1);
        wait_line(1000);
        check("lat_first_start", lat_cyc - t_done, 32'd9);
        check("l1_strobes", n_strobes - base, 32'd15);
        check("l1_hum_bcd", {20'h0, hum_bcd}, 32'h045);
        check("l1_temp_bcd", {20'h0, temp_bcd}, 32'h027);
        check("l1_bcd_valid", {31'h0, bcd_valid}, 32'h1);

        // 2: full-scale humidity, zero temperature
        base = n_strobes;
        push_line("H=255% T=000C");
        send_frame(40'hFF_00_00_00_FF, 1'b1);
        wait_line(1000);
        check("l2_strobes", n_strobes - base, 32'd15);
        check("l2_hum_bcd", {20'h0, hum_bcd}, 32'h255);
        check("l2_temp_bcd", {20'h0, temp_bcd}, 32'h000);

        // 3: checksum failure is ignored
        base = n_strobes;
        send_frame(40'h11_00_22_00_00, 1'b0);
        repeat (20) @(negedge clk);
        check("bad_busy", {31'h0, busy}, 32'h0);
        check("bad_strobes", n_strobes - base, 32'd0);
        check("bad_bcd_valid", {31'h0, bcd_valid}, 32'h1);
        check("bad_hum_hold", {20'h0, hum_bcd}, 32'h255);

        // 4: overrun during byte 5
        base = n_strobes;
        dbase = n_dropped;
        push_line("H=099% T=009C");
        send_frame(40'h63_00_09_00_00, 1'b1);
        wait_strobes(base + 5, 1000);
        send_frame(40'h11_00_22_00_00, 1'b1);
        wait_line(1000);
        repeat (100) @(negedge clk);
        check("drop_pulses", n_dropped - dbase, 32'd1);
        check("drop_strobes", n_strobes - base, 32'd15);
        check("drop_busy", {31'h0, busy}, 32'h0);
        check("drop_hum_bcd", {20'h0, hum_bcd}, 32'h099);
        check("drop_temp_bcd", {20'h0, temp_bcd}, 32'h009);

        // 5: uart held busy for 500 cycles
        base = n_strobes;
        force_busy = 1'b1;
        push_line("H=100% T=010C");
        send_frame(40'h64_00_0A_00_00, 1'b1);
        repeat (500) @(negedge clk);
        check("hold_strobes", n_strobes - base, 32'd0);
        check("hold_busy", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        force_busy = 1'b0;
        wait_line(1000);
        check("hold_after_strobes", n_strobes - base, 32'd15);

        // 6: reset during byte 7, then a fresh line
        base = n_strobes;
        push_line("H=012% T=034C");
        send_frame(40'h0C_00_22_00_00, 1'b1);
        wait_strobes(base + 7, 1000);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_tx_start", {31'h0, tx_start}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_bcd_valid", {31'h0, bcd_valid}, 32'h0);
        check("mid_rst_temp_bcd", {20'h0, temp_bcd}, 32'h0);
        q.delete();
        repeat (3) @(negedge clk);
        check("mid_rst_strobes", n_strobes - base, 32'd7);
        @(posedge clk); #1;
        rst = 1'b1;
        base = n_strobes;
        push_line("H=200% T=128C");
        send_frame(40'hC8_00_80_00_00, 1'b1);
        wait_line(1000);
        check("post_rst_strobes", n_strobes - base, 32'd15);
        check("post_rst_hum_bcd", {20'h0, hum_bcd}, 32'h200);
        check("post_rst_temp_bcd", {20'h0, temp_bcd}, 32'h128);
        check("post_rst_bcd_valid", {31'h0, bcd_valid}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dht11_uart_reporter.md
Name: dht11_uart_reporter

Overview:
- Downstream consumer of the DHT11 reader's 40-bit frame.
- On each valid completion pulse it captures the integer humidity and temperature bytes and converts each to 3-digit BCD. The BCD values also feed the FND display path.
- It then streams the ASCII line "H=hhh% T=ttt\C" + CR LF, byte by byte, into the existing uart_tx through a start/busy handshake.

Parameters:
- ADD_CRLF, 1: 1 = append 0x0D 0x0A (15-byte line); 0 = 13-byte line.
- HUM_CHAR, 8'h48 ("H"): first character of the humidity field.
- TEMP_CHAR, 8'h54 ("T"): first character of the temperature field.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset; 0 = reset.
- data  in  40  DHT11 frame: [39:32] humidity integer, [23:16] temperature integer; other bytes ignored.
- done  in  1  one-cycle completion pulse from the DHT11 reader.
- vaild  in  1  checksum-ok flag, sampled together with done.
- tx_busy  in  1  uart_tx busy level.
- tx_data  out  8  byte presented to uart_tx.
- tx_start  out  1  one-cycle strobe; tx_data is valid in that cycle.
- hum_bcd  out  12  humidity BCD {hundreds, tens, ones}.
- temp_bcd  out  12  temperature BCD.
- bcd_valid  out  1  high once the first conversion completes; stays high until reset.
- busy  out  1  high in every state except IDLE.
- dropped  out  1  one-cycle pulse when done&vaild arrives while busy.

Behaviour:
- Reset values (applied asynchronously while rst=0): all outputs 0, FSM in IDLE, byte index 0.
- States: IDLE, CONVERT, SEND, WAIT_ACK, WAIT_FREE.
- IDLE:
  - done&vaild → latch hum=data[39:32] and temp=data[23:16]; go to CONVERT.
  - done with vaild=0 → ignored; no state change, no pulse.
- CONVERT:
  - 8-cycle shift-add-3 conversion, both values in parallel.
  - On the 8th cycle, hum_bcd/temp_bcd are registered, bcd_valid is set, and the FSM goes to SEND.
  - bcd outputs change only at this point; they hold between updates.
- SEND: when tx_busy=0, drive tx_data = msg[idx] and tx_start=1 for exactly one cycle, then go to WAIT_ACK. If tx_busy=1, stay in SEND.
- WAIT_ACK: wait for tx_busy=1. This absorbs the uart's one-cycle registration latency.
- WAIT_FREE:
  - Wait for tx_busy=0.
  - If idx == LEN-1: idx := 0, go to IDLE.
  - Otherwise idx := idx+1, go to SEND.
- Message and ASCII rules:
  - msg order: HUM_CHAR, "=", h2, h1, h0, "%", " ", TEMP_CHAR, "=", t2, t1, t0, "C", [0x0D, 0x0A].
  - LEN = 15 when ADD_CRLF=1, else 13.
  - Digit ASCII = 8'h30 + BCD nibble.
  - Leading zeros are always sent, so the full range 0..255 prints as 000..255.
- Latency: done at cycle 0 → CONVERT in cycles 1–8 → SEND at cycle 9 → first tx_start at cycle 9 if tx_busy=0.
- Overrun:
  - done&vaild in any non-IDLE state → dropped=1 for one cycle.
  - Latched values, idx and the message in flight are unaffected; the new frame is discarded.
- Simultaneous events: return to IDLE and a new done in the same cycle → the done is treated as dropped (FSM still in WAIT_FREE).
- tx_start is never asserted while tx_busy=1, and never on two consecutive cycles.
- Reset mid-transmission: all state clears immediately. No further bytes are sent. The partial line is not resumed.

Decomposition:
- Package dht11_pkg holds:
  - state encoding localparams;
  - ASCII constants (CHAR_EQ 8'h3D, CHAR_PCT 8'h25, CHAR_SP 8'h20, CHAR_C 8'h43, CR 8'h0D, LF 8'h0A, ZERO 8'h30);
  - field bit ranges HUM_MSB/LSB and TEMP_MSB/LSB.
- One sub-module, bin8_to_bcd:
  - sequential double-dabble with start/done;
  - 8 cycles, 12-bit output;
  - instantiated twice.
- Message byte selection is a combinational mux indexed by idx, inside the top.

Test Plan:
- data=40'h2D_00_1B_00_48 with done=vaild=1, uart model with busy 10 cycles/byte → bytes "H=045% T=027C",0D,0A (15 strobes); hum_bcd=12'h045, temp_bcd=12'h027, bcd_valid=1; first tx_start 9 cycles after done.
- data[39:32]=8'hFF, data[23:16]=8'h00 → "H=255% T=000C\r\n"; hum_bcd=12'h255, temp_bcd=12'h000.
- done=1, vaild=0 → busy stays 0, no tx_start, bcd_valid unchanged.
- Second done&vaild during byte 5 → dropped pulses once; original 15 bytes complete unchanged; no second line.
- tx_busy forced high for 500 cycles at SEND → tx_start held 0; after release, exactly one strobe per byte.
- rst=0 during byte 7 → tx_start=0, busy=0 immediately; next valid done sends a complete line from "H".
